// File: rtl/cv32e40p_fpu_lat_pipe_if.sv
// Request/response bundle between the FPU datapath, the latency pipe and writeback.
interface cv32e40p_fpu_lat_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_class;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [TAG_WIDTH-1:0]  resp_tag;
  logic [DATA_WIDTH-1:0] resp_data;

  // FPU / writeback side
  modport master (
    output req_valid, req_class, req_tag, req_data, resp_ready,
    input  req_ready, resp_valid, resp_tag, resp_data
  );

  // latency pipe side
  modport slave (
    input  req_valid, req_class, req_tag, req_data, resp_ready,
    output req_ready, resp_valid, resp_tag, resp_data
  );
endinterface

// File: rtl/cv32e40p_fpu_lat_pipe.sv
// Per-class latency pipe for FPU results. Ops enter stage S[L] and shift toward
// S[1], which drives writeback; L=0 ops bypass the stages combinationally.
module cv32e40p_fpu_lat_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int ADDMUL_LAT = 0,
  parameter int OTHERS_LAT = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  cv32e40p_fpu_lat_pipe_if.slave      bus,
  output logic                        busy_o,
  output logic [15:0]                 stall_cnt_o
);
  localparam int MAX_LAT = (ADDMUL_LAT > OTHERS_LAT) ? ADDMUL_LAT : OTHERS_LAT;
  localparam int SD      = (MAX_LAT == 0) ? 1 : MAX_LAT;

  if (ADDMUL_LAT < 0 || ADDMUL_LAT > 4 || OTHERS_LAT < 0 || OTHERS_LAT > 4) begin : g_bad_lat
    $error("cv32e40p_fpu_lat_pipe: latency parameters must be in 0..4");
  end

  logic [SD:1]                 w_vld;
  logic [SD:1][TAG_WIDTH-1:0]  w_tag;
  logic [SD:1][DATA_WIDTH-1:0] w_data;

  logic [2:0] w_lat;
  logic       w_lat0;
  logic       w_blk;
  logic       w_stall;
  logic       w_rdy;
  logic       w_acc;
  logic       w_pass;
  logic [15:0] r_cnt;

  // latency of the offered op and whether an older op would land at or after it
  always_comb begin
    w_lat  = bus.req_class ? 3'(OTHERS_LAT) : 3'(ADDMUL_LAT);
    w_lat0 = (w_lat == 3'd0);
    w_blk  = 1'b0;
    for (int j = 1; j <= SD; j++) begin
      // S[L] itself may be occupied: it shifts down the same edge the new op loads.
      if (w_vld[j] && (w_lat0 || j > int'(w_lat))) w_blk = 1'b1;
    end
  end

  assign w_stall = w_vld[1] & ~bus.resp_ready;
  assign w_rdy   = ~flush_i & ~w_blk & ~w_stall & (~w_lat0 | bus.resp_ready);
  assign w_acc   = bus.req_valid & w_rdy;
  assign w_pass  = w_acc & w_lat0;

  assign bus.req_ready  = w_rdy;
  assign bus.resp_valid = ~flush_i & (w_vld[1] | w_pass);
  assign bus.resp_tag   = w_vld[1] ? w_tag[1]  : bus.req_tag;
  assign bus.resp_data  = w_vld[1] ? w_data[1] : bus.req_data;

  assign busy_o      = |w_vld;
  assign stall_cnt_o = r_cnt;

  if (MAX_LAT > 0) begin : g_pipe
    for (genvar j = 1; j <= MAX_LAT; j++) begin : g_stg
      logic                  r_vld;
      logic [TAG_WIDTH-1:0]  r_tag;
      logic [DATA_WIDTH-1:0] r_data;
      logic                  w_load;
      logic                  w_nxt_vld;
      logic [TAG_WIDTH-1:0]  w_nxt_tag;
      logic [DATA_WIDTH-1:0] w_nxt_data;

      assign w_load = w_acc & (w_lat == 3'(j));

      if (j < MAX_LAT) begin : g_mid
        assign w_nxt_vld  = w_vld[j+1];
        assign w_nxt_tag  = w_tag[j+1];
        assign w_nxt_data = w_data[j+1];
      end else begin : g_top
        assign w_nxt_vld  = 1'b0;
        assign w_nxt_tag  = '0;
        assign w_nxt_data = '0;
      end

      // valid bit: flush clears, load wins over shift, stall holds
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_vld <= 1'b0;
        else if (flush_i)  r_vld <= 1'b0;
        else if (w_load)   r_vld <= 1'b1;
        else if (!w_stall) r_vld <= w_nxt_vld;
      end

      // payload follows the valid bit; no reset needed
      always_ff @(posedge clk) begin
        if (w_load) begin
          r_tag  <= bus.req_tag;
          r_data <= bus.req_data;
        end else if (!w_stall) begin
          r_tag  <= w_nxt_tag;
          r_data <= w_nxt_data;
        end
      end

      assign w_vld[j]  = r_vld;
      assign w_tag[j]  = r_tag;
      assign w_data[j] = r_data;
    end
  end else begin : g_none
    assign w_vld  = '0;
    assign w_tag  = '0;
    assign w_data = '0;
  end

  // saturating count of offered-but-refused cycles; flush cycles are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= 16'd0;
    else if (!flush_i && bus.req_valid && !w_rdy && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end
endmodule

// File: tb/tb_cv32e40p_fpu_lat_pipe.sv
// Directed bench: four pipe configurations driven from tables and short sequences.
module tb_cv32e40p_fpu_lat_pipe;
  logic clk, rst_n;
  logic fl_a, fl_b, fl_c, fl_d;
  logic bz_a, bz_b, bz_c, bz_d;
  logic [15:0] sc_a, sc_b, sc_c, sc_d;
  int n_chk = 0, n_fail = 0;

  cv32e40p_fpu_lat_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) ia();
  cv32e40p_fpu_lat_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) ib();
  cv32e40p_fpu_lat_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) ic();
  cv32e40p_fpu_lat_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) id();

  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(3), .OTHERS_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_a), .bus(ia), .busy_o(bz_a), .stall_cnt_o(sc_a));
  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(2), .OTHERS_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_b), .bus(ib), .busy_o(bz_b), .stall_cnt_o(sc_b));
  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(0), .OTHERS_LAT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_c), .bus(ic), .busy_o(bz_c), .stall_cnt_o(sc_c));
  cv32e40p_fpu_lat_pipe #(.ADDMUL_LAT(4), .OTHERS_LAT(4)) u_d (
    .clk(clk), .rst_n(rst_n), .flush_i(fl_d), .bus(id), .busy_o(bz_d), .stall_cnt_o(sc_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic       cls;
    logic [4:0] tag;
    logic       rr;
    logic       e_rdy;
    logic       e_rv;
    logic [4:0] e_tag;
    logic       e_busy;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic v, logic c, logic [4:0] t, logic rr,
                              logic er, logic erv, logic [4:0] et, logic eb);
    vec_t r;
    r.vld = v; r.cls = c; r.tag = t; r.rr = rr;
    r.e_rdy = er; r.e_rv = erv; r.e_tag = et; r.e_busy = eb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic put(input int d, input logic v, input logic c, input logic [4:0] t, input logic rr);
    logic [31:0] dt;
    dt = 32'hD000_0000 | {27'd0, t};
    case (d)
      0: begin ia.req_valid = v; ia.req_class = c; ia.req_tag = t; ia.req_data = dt; ia.resp_ready = rr; end
      1: begin ib.req_valid = v; ib.req_class = c; ib.req_tag = t; ib.req_data = dt; ib.resp_ready = rr; end
      2: begin ic.req_valid = v; ic.req_class = c; ic.req_tag = t; ic.req_data = dt; ic.resp_ready = rr; end
      default: begin id.req_valid = v; id.req_class = c; id.req_tag = t; id.req_data = dt; id.resp_ready = rr; end
    endcase
  endtask

  task automatic get(input int d, output logic rdy, output logic rv, output logic [4:0] tg,
                     output logic [31:0] dt, output logic bz, output logic [15:0] sc);
    case (d)
      0: begin rdy = ia.req_ready; rv = ia.resp_valid; tg = ia.resp_tag; dt = ia.resp_data; bz = bz_a; sc = sc_a; end
      1: begin rdy = ib.req_ready; rv = ib.resp_valid; tg = ib.resp_tag; dt = ib.resp_data; bz = bz_b; sc = sc_b; end
      2: begin rdy = ic.req_ready; rv = ic.resp_valid; tg = ic.resp_tag; dt = ic.resp_data; bz = bz_c; sc = sc_c; end
      default: begin rdy = id.req_ready; rv = id.resp_valid; tg = id.resp_tag; dt = id.resp_data; bz = bz_d; sc = sc_d; end
    endcase
  endtask

  // apply tab[] to DUT d one cycle per record, checking at the falling edge
  task automatic run_tab(input int d, input string nm);
    logic rdy, rv, bz;
    logic [4:0] tg;
    logic [31:0] dt;
    logic [15:0] sc;
    for (int i = 0; i < tab.size(); i++) begin
      put(d, tab[i].vld, tab[i].cls, tab[i].tag, tab[i].rr);
      @(negedge clk);
      get(d, rdy, rv, tg, dt, bz, sc);
      chk($sformatf("%s[%0d].req_ready", nm, i), {31'd0, rdy}, {31'd0, tab[i].e_rdy});
      chk($sformatf("%s[%0d].resp_valid", nm, i), {31'd0, rv}, {31'd0, tab[i].e_rv});
      chk($sformatf("%s[%0d].busy", nm, i), {31'd0, bz}, {31'd0, tab[i].e_busy});
      if (tab[i].e_rv) begin
        chk($sformatf("%s[%0d].resp_tag", nm, i), {27'd0, tg}, {27'd0, tab[i].e_tag});
        chk($sformatf("%s[%0d].resp_data", nm, i), dt, 32'hD000_0000 | {27'd0, tab[i].e_tag});
      end
      @(posedge clk); #1;
    end
    put(d, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic rdy, rv, bz, seen;
    logic [4:0] tg;
    logic [31:0] dt;
    logic [15:0] sc;

    rst_n = 1'b0;
    fl_a = 1'b0; fl_b = 1'b0; fl_c = 1'b0; fl_d = 1'b0;
    for (int d = 0; d < 4; d++) put(d, 1'b0, 1'b0, 5'd0, 1'b1);

    // reset state, checked before any clock edge
    #1;
    for (int d = 0; d < 4; d++) begin
      get(d, rdy, rv, tg, dt, bz, sc);
      chk($sformatf("rst%0d.resp_valid", d), {31'd0, rv}, 32'd0);
      chk($sformatf("rst%0d.busy", d), {31'd0, bz}, 32'd0);
      chk($sformatf("rst%0d.stall_cnt", d), {16'd0, sc}, 32'd0);
    end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      get(d, rdy, rv, tg, dt, bz, sc);
      chk($sformatf("post_rst%0d.req_ready", d), {31'd0, rdy}, 32'd1);
    end
    @(posedge clk); #1;

    // A: add/mul=3, others=1 -- latency, class ordering
    tab.delete();
    tab.push_back(mk(1, 0, 5,  1, 1, 0, 0,  0));
    tab.push_back(mk(1, 1, 7,  1, 0, 0, 0,  1));
    tab.push_back(mk(1, 1, 7,  1, 0, 0, 0,  1));
    tab.push_back(mk(1, 1, 7,  1, 1, 1, 5,  1));
    tab.push_back(mk(0, 1, 0,  1, 1, 1, 7,  1));
    tab.push_back(mk(0, 1, 0,  1, 1, 0, 0,  0));
    tab.push_back(mk(1, 1, 9,  1, 1, 0, 0,  0));
    tab.push_back(mk(1, 0, 10, 1, 1, 1, 9,  1));
    tab.push_back(mk(0, 0, 0,  1, 1, 0, 0,  1));
    tab.push_back(mk(0, 0, 0,  1, 1, 0, 0,  1));
    tab.push_back(mk(0, 0, 0,  1, 1, 1, 10, 1));
    tab.push_back(mk(0, 0, 0,  1, 1, 0, 0,  0));
    run_tab(0, "A");
    chk("A.stall_cnt", {16'd0, sc_a}, 32'd2);

    // B: both=2 -- back-to-back accepts with a writeback stall
    tab.delete();
    tab.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 0, 2, 1, 1, 0, 0, 1));
    tab.push_back(mk(1, 0, 3, 1, 1, 1, 1, 1));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1));
    tab.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1));
    tab.push_back(mk(0, 0, 0, 1, 1, 1, 3, 1));
    tab.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    run_tab(1, "B");
    chk("B.stall_cnt", {16'd0, sc_b}, 32'd0);

    // C: both=0 -- pass-through blocked by writeback for five cycles
    put(2, 1'b1, 1'b0, 5'd4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      get(2, rdy, rv, tg, dt, bz, sc);
      chk($sformatf("C.block%0d.req_ready", k), {31'd0, rdy}, 32'd0);
      @(posedge clk); #1;
    end
    put(2, 1'b1, 1'b0, 5'd4, 1'b1);
    @(negedge clk);
    get(2, rdy, rv, tg, dt, bz, sc);
    chk("C.pass.req_ready", {31'd0, rdy}, 32'd1);
    chk("C.pass.resp_valid", {31'd0, rv}, 32'd1);
    chk("C.pass.resp_tag", {27'd0, tg}, 32'd4);
    chk("C.pass.resp_data", dt, 32'hD000_0004);
    chk("C.pass.busy", {31'd0, bz}, 32'd0);
    chk("C.pass.stall_cnt", {16'd0, sc}, 32'd5);
    @(posedge clk); #1;
    // flush cycle: refused, no response, not counted as a stall
    fl_c = 1'b1;
    @(negedge clk);
    get(2, rdy, rv, tg, dt, bz, sc);
    chk("C.flush.req_ready", {31'd0, rdy}, 32'd0);
    chk("C.flush.resp_valid", {31'd0, rv}, 32'd0);
    @(posedge clk); #1;
    fl_c = 1'b0;
    put(2, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("C.flush.stall_cnt", {16'd0, sc_c}, 32'd5);
    // saturation
    put(2, 1'b1, 1'b0, 5'd4, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    chk("C.sat.stall_cnt", {16'd0, sc_c}, 32'h0000_FFFF);
    put(2, 1'b0, 1'b0, 5'd0, 1'b1);

    // D: both=4 -- flush with two ops in flight
    put(3, 1'b1, 1'b0, 5'd11, 1'b1); @(posedge clk); #1;
    put(3, 1'b1, 1'b0, 5'd12, 1'b1); @(posedge clk); #1;
    put(3, 1'b1, 1'b0, 5'd13, 1'b1); fl_d = 1'b1;
    @(negedge clk);
    get(3, rdy, rv, tg, dt, bz, sc);
    chk("D.flush.req_ready", {31'd0, rdy}, 32'd0);
    chk("D.flush.resp_valid", {31'd0, rv}, 32'd0);
    chk("D.flush.busy_before", {31'd0, bz}, 32'd1);
    @(posedge clk); #1;
    fl_d = 1'b0;
    put(3, 1'b0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    chk("D.flush.busy_after", {31'd0, bz_d}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (id.resp_valid) seen = 1'b1;
    end
    chk("D.flush.no_resp", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;

    // D: async reset with three ops in flight, oldest at S[1]
    put(3, 1'b1, 1'b0, 5'd21, 1'b1); @(posedge clk); #1;
    put(3, 1'b1, 1'b0, 5'd22, 1'b1); @(posedge clk); #1;
    put(3, 1'b1, 1'b0, 5'd23, 1'b1); @(posedge clk); #1;
    put(3, 1'b0, 1'b0, 5'd0, 1'b1);  @(posedge clk); #1;
    @(negedge clk);
    chk("D.pre_rst.resp_valid", {31'd0, id.resp_valid}, 32'd1);
    chk("D.pre_rst.resp_tag", {27'd0, id.resp_tag}, 32'd21);
    #1 rst_n = 1'b0;
    #1;
    chk("D.rst.resp_valid", {31'd0, id.resp_valid}, 32'd0);
    chk("D.rst.busy", {31'd0, bz_d}, 32'd0);
    chk("D.rst.stall_cnt", {16'd0, sc_d}, 32'd0);
    chk("A.rst.stall_cnt", {16'd0, sc_a}, 32'd0);
    chk("C.rst.stall_cnt", {16'd0, sc_c}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("D.rel.req_ready", {31'd0, id.req_ready}, 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (id.resp_valid || bz_d) seen = 1'b1;
    end
    chk("D.rel.no_resp", {31'd0, seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
